// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl - multiplexed 7-segment scan controller for NDIG digits.
//
// Scans the digits one at a time. Each digit slot is split into 16 PWM
// sub-slots of PRESC clocks each. Sub-slot 0 is a dead slot with every anode
// off, which prevents ghosting. The remaining sub-slots light the digit while
// sub <= bright.
//
// Per-digit features: blanking, blinking (BLINK_FRAMES frames per half
// period), and leading-zero suppression.
//
// Input values pass through a pending/active double buffer. The display only
// changes on a frame boundary.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   hex_in       digit values, digit i = hex_in[4i+3:4i], digit 0 rightmost
//   dp_in        decimal points, active-high
//   blank_in     1 = force digit dark
//   blink_in     1 = digit blinks
//   lzs_en       leading-zero suppression enable (live)
//   bright       PWM brightness 0..15 (live)
//   load         capture hex/dp/blank/blink into the pending buffer
//   an           anode enables, active-low
//   sseg         {dp,g..a}, active-low
//   frame_start  1-cycle pulse on the first output cycle of digit 0
module sseg_scan_ctrl #(
  parameter int NDIG         = 4,
  parameter int PRESC        = 195,
  parameter int BLINK_FRAMES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4*NDIG-1:0] hex_in,
  input  logic [NDIG-1:0]   dp_in,
  input  logic [NDIG-1:0]   blank_in,
  input  logic [NDIG-1:0]   blink_in,
  input  logic              lzs_en,
  input  logic [3:0]        bright,
  input  logic              load,
  output logic [NDIG-1:0]   an,
  output logic [7:0]        sseg,
  output logic              frame_start
);

  localparam int PW = $clog2(PRESC);
  localparam int DW = $clog2(NDIG);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NDIG - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  // Active-low gfedcba glyphs for 0-F.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      4'hF:    g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  logic [PW-1:0]            presc_r;
  logic [3:0]               sub_r;
  logic [DW-1:0]            dig_r;
  logic [BW-1:0]            blink_cnt_r;
  logic                     blink_ph_r;

  logic [NDIG-1:0][3:0]     hex_p_r;
  logic [NDIG-1:0][3:0]     hex_a_r;
  logic [NDIG-1:0]          dp_p_r;
  logic [NDIG-1:0]          blank_p_r;
  logic [NDIG-1:0]          blink_p_r;
  logic [NDIG-1:0]          dp_a_r;
  logic [NDIG-1:0]          blank_a_r;
  logic [NDIG-1:0]          blink_a_r;

  logic                     presc_wrap_s;
  logic                     sub_wrap_s;
  logic                     frame_wrap_s;
  logic                     zero_above_s;
  logic [NDIG-1:0]          lz_s;
  logic                     dk_s;
  logic                     lit_s;
  logic [NDIG-1:0]          an_nxt_s;
  logic [7:0]               sseg_nxt_s;
  logic                     fs_nxt_s;

  // Wrap detection for the prescaler -> sub-slot -> digit chain.
  always_comb begin
    presc_wrap_s = (presc_r == PRESC_LAST);
    sub_wrap_s   = presc_wrap_s && (sub_r == 4'd15);
    frame_wrap_s = sub_wrap_s && (dig_r == DIG_LAST);
  end

  // Timing chain: prescaler, sub-slot, digit index, blink counter and phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_r     <= '0;
      sub_r       <= 4'd0;
      dig_r       <= '0;
      blink_cnt_r <= '0;
      blink_ph_r  <= 1'b0;
    end else begin
      if (presc_wrap_s) begin
        presc_r <= '0;
        sub_r   <= sub_r + 4'd1;
      end else begin
        presc_r <= presc_r + PW'(1);
        sub_r   <= sub_r;
      end
      if (sub_wrap_s) begin
        dig_r <= (dig_r == DIG_LAST) ? '0 : dig_r + DW'(1);
      end else begin
        dig_r <= dig_r;
      end
      if (frame_wrap_s && (blink_cnt_r == BLINK_LAST)) begin
        blink_cnt_r <= '0;
        blink_ph_r  <= ~blink_ph_r;
      end else if (frame_wrap_s) begin
        blink_cnt_r <= blink_cnt_r + BW'(1);
        blink_ph_r  <= blink_ph_r;
      end else begin
        blink_cnt_r <= blink_cnt_r;
        blink_ph_r  <= blink_ph_r;
      end
    end
  end

  // Pending/active double buffer.
  // A load on the boundary cycle goes straight through to active.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hex_p_r   <= '0;
      dp_p_r    <= '0;
      blank_p_r <= '1;
      blink_p_r <= '0;
      hex_a_r   <= '0;
      dp_a_r    <= '0;
      blank_a_r <= '1;
      blink_a_r <= '0;
    end else begin
      if (load) begin
        hex_p_r   <= hex_in;
        dp_p_r    <= dp_in;
        blank_p_r <= blank_in;
        blink_p_r <= blink_in;
      end else begin
        hex_p_r   <= hex_p_r;
        dp_p_r    <= dp_p_r;
        blank_p_r <= blank_p_r;
        blink_p_r <= blink_p_r;
      end
      if (frame_wrap_s && load) begin
        hex_a_r   <= hex_in;
        dp_a_r    <= dp_in;
        blank_a_r <= blank_in;
        blink_a_r <= blink_in;
      end else if (frame_wrap_s) begin
        hex_a_r   <= hex_p_r;
        dp_a_r    <= dp_p_r;
        blank_a_r <= blank_p_r;
        blink_a_r <= blink_p_r;
      end else begin
        hex_a_r   <= hex_a_r;
        dp_a_r    <= dp_a_r;
        blank_a_r <= blank_a_r;
        blink_a_r <= blink_a_r;
      end
    end
  end

  // Dark/lit decision for the current digit, and next output values.
  // Leading-zero suppression walks from the top digit down. A digit is
  // suppressed while it and every digit above it is zero with no dp.
  // Digit 0 is never suppressed.
  always_comb begin
    zero_above_s = 1'b1;
    lz_s         = '0;
    for (int d = NDIG - 1; d >= 0; d--) begin
      zero_above_s = zero_above_s && (hex_a_r[d] == 4'd0) && !dp_a_r[d];
      lz_s[d]      = lzs_en && (d != 0) && zero_above_s;
    end
    dk_s  = blank_a_r[dig_r] || (blink_a_r[dig_r] && blink_ph_r) || lz_s[dig_r];
    lit_s = (sub_r != 4'd0) && (sub_r <= bright) && !dk_s;
    an_nxt_s   = '1;
    sseg_nxt_s = 8'hFF;
    if (lit_s) begin
      an_nxt_s[dig_r] = 1'b0;
      sseg_nxt_s      = {~dp_a_r[dig_r], glyph(hex_a_r[dig_r])};
    end else begin
      an_nxt_s   = '1;
      sseg_nxt_s = 8'hFF;
    end
    fs_nxt_s = (presc_r == '0) && (sub_r == 4'd0) && (dig_r == '0);
  end

  // Registered pin drivers, one clock behind the counter state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      an          <= '1;
      sseg        <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      an          <= an_nxt_s;
      sseg        <= sseg_nxt_s;
      frame_start <= fs_nxt_s;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl (NDIG=4, PRESC=2, BLINK_FRAMES=2).
// The reference model derives the digit, sub-slot and blink phase from the
// elapsed cycle count since reset release using plain division.
module tb_sseg_scan_ctrl;
  localparam int NDIG  = 4;
  localparam int PRESC = 2;
  localparam int BF    = 2;
  localparam int SLOT  = PRESC * 16;
  localparam int FRAME = SLOT * NDIG;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [3:0]  blink_in;
  logic        lzs_en;
  logic [3:0]  bright;
  logic        load;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  // Cycle count since release = counter state before the next edge.
  int t = 0;

  logic [15:0] m_hex_p;
  logic [15:0] m_hex_a;
  logic [3:0]  m_dp_p;
  logic [3:0]  m_dp_a;
  logic [3:0]  m_blank_p;
  logic [3:0]  m_blank_a;
  logic [3:0]  m_blink_p;
  logic [3:0]  m_blink_a;
  logic [3:0]  exp_an;
  logic [7:0]  exp_sseg;
  logic        exp_fs;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sseg_scan_ctrl #(.NDIG(NDIG), .PRESC(PRESC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .hex_in(hex_in), .dp_in(dp_in), .blank_in(blank_in),
    .blink_in(blink_in), .lzs_en(lzs_en), .bright(bright), .load(load),
    .an(an), .sseg(sseg), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic lz_dark(input int d);
    if (!lzs_en || d == 0) return 1'b0;
    for (int j = d; j < NDIG; j++) begin
      if (m_hex_a[4*j +: 4] != 4'd0 || m_dp_a[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Predict this edge's outputs, clock once, then fold the sampled inputs
  // into the model. The caller compares afterwards.
  task automatic step();
    int   dig;
    int   sub;
    int   frame;
    logic phase;
    logic dark;
    logic lit;
    if (!reset) begin
      exp_an   = 4'hF;
      exp_sseg = 8'hFF;
      exp_fs   = 1'b0;
    end else begin
      dig      = (t / SLOT) % NDIG;
      sub      = (t / PRESC) % 16;
      frame    = t / FRAME;
      phase    = ((frame / BF) % 2) == 1;
      dark     = m_blank_a[dig] || (m_blink_a[dig] && phase) || lz_dark(dig);
      lit      = (sub != 0) && (sub <= int'(bright)) && !dark;
      exp_an   = 4'hF;
      exp_sseg = 8'hFF;
      if (lit) begin
        exp_an[dig] = 1'b0;
        exp_sseg    = {~m_dp_a[dig], glyph_tab[m_hex_a[4*dig +: 4]]};
      end
      exp_fs = (t % FRAME) == 0;
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      t = 0;
      m_hex_p = 16'h0; m_dp_p = 4'h0; m_blank_p = 4'hF; m_blink_p = 4'h0;
      m_hex_a = 16'h0; m_dp_a = 4'h0; m_blank_a = 4'hF; m_blink_a = 4'h0;
    end else begin
      if (load) begin
        m_hex_p = hex_in; m_dp_p = dp_in; m_blank_p = blank_in; m_blink_p = blink_in;
      end
      if ((t % FRAME) == FRAME - 1) begin
        m_hex_a = m_hex_p; m_dp_a = m_dp_p; m_blank_a = m_blank_p; m_blink_a = m_blink_p;
      end
      t++;
    end
  endtask

  task automatic run_to_boundary();
    while ((t % FRAME) != 0) step();
  endtask

  task automatic load_values(input logic [15:0] h, input logic [3:0] dp,
                             input logic [3:0] bl, input logic [3:0] bk);
    hex_in = h; dp_in = dp; blank_in = bl; blink_in = bk; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    int fs_t [$];
    int lit_seen = 0;
    reset = 1'b0; hex_in = 16'h0; dp_in = 4'h0; blank_in = 4'h0; blink_in = 4'h0;
    lzs_en = 1'b0; bright = 4'd15; load = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if (an !== 4'hF || sseg !== 8'hFF || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold an=%b sseg=%h fs=%b required an=1111 sseg=ff fs=0", an, sseg, frame_start);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      step();
      checks++;
      if (an !== exp_an || sseg !== exp_sseg || frame_start !== exp_fs) begin
        errors++;
        $display("FAIL reset_model t=%0d an=%b/%b sseg=%h/%h fs=%b/%b", t, an, exp_an, sseg, exp_sseg, frame_start, exp_fs);
      end
      if (frame_start === 1'b1) fs_t.push_back(i);
      if (an !== 4'hF) lit_seen++;
    end
    checks++;
    if (lit_seen != 0) begin
      errors++;
      $display("FAIL reset_dark lit_cycles=%0d required 0", lit_seen);
    end
    checks++;
    if (fs_t.size() < 2 || fs_t[0] != 0 || fs_t[1] - fs_t[0] != FRAME) begin
      errors++;
      $display("FAIL frame_period pulses=%0d first=%0d period=%0d required first=0 period=%0d",
               fs_t.size(), (fs_t.size() > 0) ? fs_t[0] : -1,
               (fs_t.size() > 1) ? fs_t[1] - fs_t[0] : -1, FRAME);
    end
  endtask

  task automatic test_scan();
    int          lowcnt [4] = '{0, 0, 0, 0};
    int          dead_bad = 0;
    int          d2_bad = 0;
    logic [3:0]  pat;
    bright = 4'd15; lzs_en = 1'b0;
    load_values(16'h3210, 4'h0, 4'h0, 4'h0);
    run_to_boundary();
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if (an !== exp_an || sseg !== exp_sseg || frame_start !== exp_fs) begin
        errors++;
        $display("FAIL scan_model t=%0d an=%b/%b sseg=%h/%h fs=%b/%b", t, an, exp_an, sseg, exp_sseg, frame_start, exp_fs);
      end
      for (int d = 0; d < NDIG; d++) begin
        pat = 4'hF;
        pat[d] = 1'b0;
        if (an === pat) lowcnt[d]++;
      end
      if ((i % SLOT) < PRESC && an !== 4'hF) dead_bad++;
      if (an === 4'b1011 && sseg !== 8'hA4) d2_bad++;
    end
    for (int d = 0; d < NDIG; d++) begin
      checks++;
      if (lowcnt[d] != SLOT - PRESC) begin
        errors++;
        $display("FAIL scan_slot digit=%0d lit=%0d required %0d", d, lowcnt[d], SLOT - PRESC);
      end
    end
    checks++;
    if (dead_bad != 0 || d2_bad != 0) begin
      errors++;
      $display("FAIL scan_dead dead_lit=%0d digit2_bad=%0d required 0 and 0", dead_bad, d2_bad);
    end
  endtask

  task automatic test_pwm();
    int lowcnt [4];
    int outside;
    logic [3:0] brs [2] = '{4'd4, 4'd0};
    for (int k = 0; k < 2; k++) begin
      run_to_boundary();
      bright = brs[k];
      lowcnt = '{0, 0, 0, 0};
      outside = 0;
      for (int i = 0; i < FRAME; i++) begin
        step();
        checks++;
        if (an !== exp_an || sseg !== exp_sseg || frame_start !== exp_fs) begin
          errors++;
          $display("FAIL pwm_model t=%0d an=%b/%b sseg=%h/%h fs=%b/%b", t, an, exp_an, sseg, exp_sseg, frame_start, exp_fs);
        end
        for (int d = 0; d < NDIG; d++) if (an[d] === 1'b0) lowcnt[d]++;
        if (((i % SLOT) < PRESC || (i % SLOT) >= PRESC * (int'(brs[k]) + 1)) && an !== 4'hF) outside++;
      end
      for (int d = 0; d < NDIG; d++) begin
        checks++;
        if (lowcnt[d] != PRESC * int'(brs[k])) begin
          errors++;
          $display("FAIL pwm_duty bright=%0d digit=%0d low=%0d required %0d", brs[k], d, lowcnt[d], PRESC * int'(brs[k]));
        end
      end
      checks++;
      if (outside != 0) begin
        errors++;
        $display("FAIL pwm_window bright=%0d lit_outside=%0d required 0", brs[k], outside);
      end
    end
    bright = 4'd15;
  endtask

  task automatic test_lzs();
    logic [15:0] hx [3]   = '{16'h0050, 16'h0000, 16'h0000};
    logic [3:0]  dpv [3]  = '{4'b0000, 4'b0000, 4'b1000};
    logic [3:0]  mask [3] = '{4'b0011, 4'b0001, 4'b1111};
    int litcnt [4];
    int dp3_bad;
    lzs_en = 1'b1; bright = 4'd15;
    for (int k = 0; k < 3; k++) begin
      load_values(hx[k], dpv[k], 4'h0, 4'h0);
      run_to_boundary();
      litcnt = '{0, 0, 0, 0};
      dp3_bad = 0;
      for (int i = 0; i < FRAME; i++) begin
        step();
        checks++;
        if (an !== exp_an || sseg !== exp_sseg || frame_start !== exp_fs) begin
          errors++;
          $display("FAIL lzs_model t=%0d an=%b/%b sseg=%h/%h fs=%b/%b", t, an, exp_an, sseg, exp_sseg, frame_start, exp_fs);
        end
        for (int d = 0; d < NDIG; d++) if (an[d] === 1'b0) litcnt[d]++;
        if (dpv[k][3] && an === 4'b0111 && sseg[7] !== 1'b0) dp3_bad++;
      end
      for (int d = 0; d < NDIG; d++) begin
        checks++;
        if (litcnt[d] != (mask[k][d] ? SLOT - PRESC : 0)) begin
          errors++;
          $display("FAIL lzs_lit case=%0d digit=%0d lit=%0d required %0d", k, d, litcnt[d], mask[k][d] ? SLOT - PRESC : 0);
        end
      end
      checks++;
      if (dp3_bad != 0) begin
        errors++;
        $display("FAIL lzs_dp3 case=%0d bad=%0d required 0", k, dp3_bad);
      end
    end
    lzs_en = 1'b0;
  endtask

  task automatic test_double_buffer();
    int ones = 0;
    int twos_now = 0;
    int twos_next = 0;
    int sevens = 0;
    run_to_boundary();
    dp_in = 4'h0; blank_in = 4'h0; blink_in = 4'h0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        load = 1'b0;
        if (f == 0 && i == 10) begin hex_in = 16'h1111; load = 1'b1; end
        if (f == 0 && i == 30) begin hex_in = 16'h2222; load = 1'b1; end
        step();
        load = 1'b0;
        checks++;
        if (an !== exp_an || sseg !== exp_sseg || frame_start !== exp_fs) begin
          errors++;
          $display("FAIL dbuf_model t=%0d an=%b/%b sseg=%h/%h fs=%b/%b", t, an, exp_an, sseg, exp_sseg, frame_start, exp_fs);
        end
        if (an !== 4'hF && sseg === 8'hF9) ones++;
        if (an !== 4'hF && sseg === 8'hA4) begin
          if (f == 0) twos_now++;
          else twos_next++;
        end
      end
    end
    checks++;
    if (ones != 0 || twos_now != 0 || twos_next != NDIG * (SLOT - PRESC)) begin
      errors++;
      $display("FAIL dbuf_mid ones=%0d twos_now=%0d twos_next=%0d required 0 0 %0d", ones, twos_now, twos_next, NDIG * (SLOT - PRESC));
    end
    while ((t % FRAME) != FRAME - 1) step();
    load_values(16'h7777, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++;
      if (an !== exp_an || sseg !== exp_sseg || frame_start !== exp_fs) begin
        errors++;
        $display("FAIL dbuf_edge_model t=%0d an=%b/%b sseg=%h/%h fs=%b/%b", t, an, exp_an, sseg, exp_sseg, frame_start, exp_fs);
      end
      if (an !== 4'hF && sseg === 8'hF8) sevens++;
    end
    checks++;
    if (sevens != NDIG * (SLOT - PRESC)) begin
      errors++;
      $display("FAIL dbuf_edge sevens=%0d required %0d", sevens, NDIG * (SLOT - PRESC));
    end
  endtask

  task automatic test_blink();
    int lit0;
    int fr;
    int need;
    load_values(16'h3210, 4'h0, 4'h0, 4'b0001);
    run_to_boundary();
    for (int f = 0; f < 4; f++) begin
      fr = t / FRAME;
      lit0 = 0;
      for (int i = 0; i < FRAME; i++) begin
        step();
        checks++;
        if (an !== exp_an || sseg !== exp_sseg || frame_start !== exp_fs) begin
          errors++;
          $display("FAIL blink_model t=%0d an=%b/%b sseg=%h/%h fs=%b/%b", t, an, exp_an, sseg, exp_sseg, frame_start, exp_fs);
        end
        if (an === 4'b1110) lit0++;
      end
      need = (((fr / BF) % 2) == 1) ? 0 : SLOT - PRESC;
      checks++;
      if (lit0 != need) begin
        errors++;
        $display("FAIL blink_frame frame=%0d lit=%0d required %0d", fr, lit0, need);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lit = 0;
    load_values(16'h3210, 4'h0, 4'h0, 4'h0);
    while ((t % FRAME) != 2 * SLOT + 6) step();
    reset = 1'b0;
    step();
    checks++;
    if (an !== 4'hF || sseg !== 8'hFF || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid an=%b sseg=%h fs=%b required an=1111 sseg=ff fs=0", an, sseg, frame_start);
    end
    reset = 1'b1;
    step();
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_fs fs=%b required 1", frame_start);
    end
    for (int i = 0; i < FRAME + 40; i++) begin
      step();
      checks++;
      if (an !== exp_an || sseg !== exp_sseg || frame_start !== exp_fs) begin
        errors++;
        $display("FAIL reset_mid_model t=%0d an=%b/%b sseg=%h/%h fs=%b/%b", t, an, exp_an, sseg, exp_sseg, frame_start, exp_fs);
      end
      if (an !== 4'hF) lit++;
    end
    checks++;
    if (lit != 0) begin
      errors++;
      $display("FAIL reset_mid_cleared lit=%0d required 0", lit);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      load = 1'b0;
      reset = 1'b1;
      if ($urandom_range(0, 39) == 0) begin
        hex_in   = 16'($urandom);
        if ($urandom_range(0, 2) == 0) hex_in = hex_in & 16'h00FF;
        dp_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        blink_in = 4'($urandom);
        load     = 1'b1;
      end
      if ($urandom_range(0, 199) == 0) bright = 4'($urandom);
      if ($urandom_range(0, 299) == 0) lzs_en = ~lzs_en;
      if ($urandom_range(0, 1499) == 0) reset = 1'b0;
      step();
      checks++;
      if (an !== exp_an || sseg !== exp_sseg || frame_start !== exp_fs) begin
        errors++;
        $display("FAIL random_model t=%0d an=%b/%b sseg=%h/%h fs=%b/%b", t, an, exp_an, sseg, exp_sseg, frame_start, exp_fs);
      end
    end
    reset = 1'b1;
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_pwm();
    test_lzs();
    test_double_buffer();
    test_blink();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
